// File: rtl/onchip_memory.sv
//------------------------------------------------------------------------------
// Module      : onchip_memory
// Description : Simple dual-port RAM, write-only port A (i_sys_clk), read-only
//               port B (i_sys_clkb), independent clocks, 1 or 2 cycle read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module onchip_memory #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic              i_sys_clk,
   input  logic              i_rst_n,
   input  logic              i_sys_clkb,
   input  logic              i_ena,
   input  logic              i_wea,
   input  logic [ADDR_W-1:0] i_addra,
   input  logic [DATA_W-1:0] i_dina,
   input  logic              i_enb,
   input  logic              i_web,
   input  logic [ADDR_W-1:0] i_addrb,
   output logic [DATA_W-1:0] o_doutb
);

   localparam int C_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [C_DEPTH] = '{default: '0};

   logic [1:0]        r_rsta_sync;
   logic [1:0]        r_rstb_sync;
   logic              w_wr_en;
   logic              w_rd_adv;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_unused_web;

   // Port B is read-only; its write enable is accepted and deliberately ignored.
   assign w_unused_web = i_web;

   // Reset release is synchronised into each clock domain; assertion is immediate.
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsta_sync <= 2'b00;
      end else begin
         r_rsta_sync <= {r_rsta_sync[0], 1'b1};
      end
   end

   always_ff @(posedge i_sys_clkb or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rstb_sync <= 2'b00;
      end else begin
         r_rstb_sync <= {r_rstb_sync[0], 1'b1};
      end
   end

   assign w_wr_en  = r_rsta_sync[1] & i_ena & i_wea;
   assign w_rd_adv = r_rstb_sync[1] & i_enb;

   always_ff @(posedge i_sys_clk) begin
      if (w_wr_en) begin
         r_mem[i_addra] <= i_dina;
      end
   end

   always_ff @(posedge i_sys_clkb or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (w_rd_adv) begin
         r_rd_data <= r_mem[i_addrb];
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_out_reg
         logic [DATA_W-1:0] r_out;

         always_ff @(posedge i_sys_clkb or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_out <= '0;
            end else if (w_rd_adv) begin
               r_out <= r_rd_data;
            end
         end

         assign o_doutb = r_out;
      end else begin : g_no_out_reg
         assign o_doutb = r_rd_data;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_onchip_memory.sv
//------------------------------------------------------------------------------
// Module      : tb_onchip_memory
// Description : Self-checking bench for onchip_memory against an array model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_onchip_memory;

   localparam int LAT = 1;

   logic        clk;
   logic        clkb;
   logic        rst_n;
   logic        ena;
   logic        wea;
   logic [7:0]  addra;
   logic [15:0] dina;
   logic        enb;
   logic        web;
   logic [7:0]  addrb;
   logic [15:0] doutb;

   logic [15:0] model [256];
   int          n_tests;
   int          n_fail;

   typedef struct {
      logic        ena;
      logic        wea;
      logic [7:0]  addr;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];

   onchip_memory #(
      .DATA_W      (16),
      .ADDR_W      (8),
      .READ_LATENCY(LAT)
   ) dut (
      .i_sys_clk (clk),
      .i_rst_n   (rst_n),
      .i_sys_clkb(clkb),
      .i_ena     (ena),
      .i_wea     (wea),
      .i_addra   (addra),
      .i_dina    (dina),
      .i_enb     (enb),
      .i_web     (web),
      .i_addrb   (addrb),
      .o_doutb   (doutb)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      clkb = 1'b0;
      #7;
      forever #20 clkb = ~clkb;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Port-A write; the model only changes when the write is qualified and reset is high.
   task automatic write_a(input logic e, input logic w, input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      ena   = e;
      wea   = w;
      addra = a;
      dina  = d;
      @(posedge clk);
      #1;
      if (e && w && rst_n) model[a] = d;
      ena = 1'b0;
      wea = 1'b0;
   endtask

   task automatic read_b(input logic [7:0] a, input logic w, output logic [15:0] q);
      @(negedge clkb);
      addrb = a;
      web   = w;
      enb   = 1'b1;
      repeat (LAT) @(posedge clkb);
      #1;
      q   = doutb;
      enb = 1'b0;
      web = 1'b0;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      repeat (4) @(posedge clkb);
      repeat (4) @(posedge clk);
   endtask

   initial begin
      logic [15:0] q;
      logic [15:0] held;
      logic [7:0]  a;
      logic [15:0] d;

      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;

      rst_n = 1'b0;
      ena   = 1'b0;
      wea   = 1'b0;
      addra = 8'h00;
      dina  = 16'h0000;
      enb   = 1'b1;
      web   = 1'b0;
      addrb = 8'h00;

      vecs[0] = '{ena: 1'b1, wea: 1'b1, addr: 8'd7,   din: 16'h1234, exp: 16'h1234};
      vecs[1] = '{ena: 1'b1, wea: 1'b0, addr: 8'd7,   din: 16'hBEEF, exp: 16'h1234};
      vecs[2] = '{ena: 1'b0, wea: 1'b1, addr: 8'd7,   din: 16'hBEEF, exp: 16'h1234};
      vecs[3] = '{ena: 1'b1, wea: 1'b1, addr: 8'd255, din: 16'hA5A5, exp: 16'hA5A5};
      vecs[4] = '{ena: 1'b1, wea: 1'b1, addr: 8'd0,   din: 16'h0001, exp: 16'h0001};
      vecs[5] = '{ena: 1'b0, wea: 1'b0, addr: 8'd0,   din: 16'hFFFF, exp: 16'h0001};
      vecs[6] = '{ena: 1'b1, wea: 1'b1, addr: 8'd0,   din: 16'hFFFF, exp: 16'hFFFF};
      vecs[7] = '{ena: 1'b1, wea: 1'b0, addr: 8'd255, din: 16'h0000, exp: 16'hA5A5};

      // Reset: output held at zero with read enable active
      #50;  check("reset_t50", doutb, 16'h0000);
      #50;  check("reset_t100", doutb, 16'h0000);
      #32;
      enb = 1'b0;
      release_reset();
      check("post_reset", doutb, 16'h0000);
      read_b(8'd200, 1'b0, q);
      check("init_zero_200", q, 16'h0000);

      // Directed write gating / boundary addresses
      foreach (vecs[i]) begin
         write_a(vecs[i].ena, vecs[i].wea, vecs[i].addr, vecs[i].din);
         read_b(vecs[i].addr, 1'b0, q);
         check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), q, vecs[i].exp);
      end

      // Fill then sweep read with port-B write enable asserted
      for (int i = 0; i < 256; i++)
         write_a(1'b1, 1'b1, 8'(i), 16'($urandom_range(1, 65535)));
      for (int i = 0; i < 256; i++) begin
         read_b(8'(i), 1'b1, q);
         check($sformatf("fill_rd%0d", i), q, model[i]);
      end
      for (int i = 0; i < 32; i++) begin
         a = 8'($urandom_range(0, 255));
         read_b(a, 1'b0, q);
         check($sformatf("reread%0d", a), q, model[a]);
      end

      // Hold: output frozen while enable is low
      read_b(8'd5, 1'b0, held);
      check("hold_first", held, model[5]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clkb);
         addrb = 8'($urandom_range(6, 255));
         @(posedge clkb);
         #1;
         check($sformatf("hold%0d", i), doutb, model[5]);
      end

      // Random interleaved traffic
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) begin
            d = 16'($urandom);
            write_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, d);
         end else begin
            read_b(a, 1'($urandom_range(0, 1)), q);
            check($sformatf("rand_rd%0d", a), q, model[a]);
         end
      end

      // Reset mid-read: pending read discarded, output cleared immediately
      write_a(1'b1, 1'b1, 8'd99, 16'hC3C3);
      read_b(8'd99, 1'b0, q);
      check("pre_rst_rd", q, 16'hC3C3);
      @(negedge clkb);
      addrb = 8'd100;
      enb   = 1'b1;
      #5;
      rst_n = 1'b0;
      #1;
      check("rst_immediate", doutb, 16'h0000);
      @(posedge clkb);
      #1;
      check("rst_held", doutb, 16'h0000);
      enb = 1'b0;
      write_a(1'b1, 1'b1, 8'd10, 16'hDEAD);
      #13;
      release_reset();
      check("rst_released", doutb, 16'h0000);
      for (int i = 0; i < 256; i++) begin
         read_b(8'(i), 1'b0, q);
         check($sformatf("post_rst_rd%0d", i), q, model[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
